// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers, placed in the E stage.
// Optional build macro MDU_MADD_EN adds the multiply-accumulate family (ops 9-12).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Valid_E,
  input  logic [3:0]  MDOp_E,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut_E,
  output logic        dbg_state_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t         state_q;
  logic           busy_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    hi_q, lo_q;
  logic [31:0]    phi_q, plo_q;
  logic [31:0]    phi_d, plo_d;
  logic           is_mul, is_div;
  logic [63:0]    prod_s, prod_u;
  logic [31:0]    quot_s, rem_s, quot_u, rem_u;

  // Sign-extending to 64 bits makes the unsigned product equal the signed one mod 2^64.
  assign prod_s = {{32{SrcA_E[31]}}, SrcA_E} * {{32{SrcB_E[31]}}, SrcB_E};
  assign prod_u = {32'b0, SrcA_E} * {32'b0, SrcB_E};
  assign quot_s = $signed(SrcA_E) / $signed(SrcB_E);
  assign rem_s  = $signed(SrcA_E) % $signed(SrcB_E);
  assign quot_u = SrcA_E / SrcB_E;
  assign rem_u  = SrcA_E % SrcB_E;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    phi_d  = hi_q;
    plo_d  = lo_q;
    case (MDOp_E)
      4'd1: begin is_mul = 1'b1; {phi_d, plo_d} = prod_s; end
      4'd2: begin is_mul = 1'b1; {phi_d, plo_d} = prod_u; end
      4'd3: begin
        is_div = 1'b1;
        if (SrcB_E != 32'd0) begin phi_d = rem_s; plo_d = quot_s; end
      end
      4'd4: begin
        is_div = 1'b1;
        if (SrcB_E != 32'd0) begin phi_d = rem_u; plo_d = quot_u; end
      end
`ifdef MDU_MADD_EN
      4'd9:  begin is_mul = 1'b1; {phi_d, plo_d} = {hi_q, lo_q} + prod_s; end
      4'd10: begin is_mul = 1'b1; {phi_d, plo_d} = {hi_q, lo_q} + prod_u; end
      4'd11: begin is_mul = 1'b1; {phi_d, plo_d} = {hi_q, lo_q} - prod_s; end
      4'd12: begin is_mul = 1'b1; {phi_d, plo_d} = {hi_q, lo_q} - prod_u; end
`endif
      default: ;
    endcase
  end

  // Handshake: Start pulses for one cycle when a valid mult/div op meets an idle unit;
  // the op is taken at that edge and Busy then stays high for exactly N cycles. Nothing
  // is accepted while Busy is high -- the hazard unit must hold the op back instead.
  assign Start = Valid_E & (is_mul | is_div) & ~busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else if (Valid_E && MDOp_E == 4'd5) begin
            hi_q <= SrcA_E;
          end else if (Valid_E && MDOp_E == 4'd6) begin
            lo_q <= SrcA_E;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_q    <= phi_q;
            lo_q    <= plo_q;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy        = busy_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign dbg_state_o = state_q;
  assign MDOut_E     = (MDOp_E == 4'd7) ? hi_q :
                       (MDOp_E == 4'd8) ? lo_q : 32'd0;

endmodule
